// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage in front of a combinational program ROM. Owns the
// program counter, registers the fetched instruction toward decode behind a
// valid/ready handshake, and reacts to branch redirects and start/halt.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse: leave IDLE and fetch from PC 0
//   halt                level: suppress new fetches while high
//   rom_addr/rom_data   ROM address (= pc) and same-cycle instruction
//   redirect_valid/_target  taken-branch PC change from execute
//   inst_out/inst_pc/inst_valid/inst_ready  output register + handshake
//   fetch_count         saturating count of accepted instructions
//   running             high while in FETCH
module fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        fetch_count,
  output logic              running
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;

  logic active;       // FETCH or HALTED: redirects are honoured
  logic do_redirect;
  logic do_load;
  logic xfer;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (halt)  state_next = S_HALTED;
      S_HALTED: if (!halt) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    running     = (state == S_FETCH);
    active      = (state == S_FETCH) || (state == S_HALTED);
    do_redirect = active && redirect_valid;
    // Redirect wins over load; the target is fetched on the following cycle.
    do_load     = (state == S_FETCH) && (!inst_valid || inst_ready) &&
                  !halt && !redirect_valid;
    xfer        = inst_valid && inst_ready;
  end

  assign rom_addr = pc;

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (state == S_IDLE) begin
      if (start) pc <= '0;
    end else if (do_redirect) begin
      pc <= redirect_target;
    end else if (do_load) begin
      pc <= pc + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
    end
  end

  // Output register toward decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (do_redirect) begin
      // Flush the wrong-path instruction; a concurrent transfer still counts.
      inst_valid <= 1'b0;
    end else if (do_load) begin
      inst_out   <= rom_data;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
    end else if (inst_ready) begin
      // Drain: the held instruction was consumed and nothing replaces it.
      inst_valid <= 1'b0;
    end
  end

  // Saturating handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 8'd0;
    end else if (xfer && (fetch_count != 8'hFF)) begin
      fetch_count <= fetch_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [3:0]  redirect_target;
  logic [15:0] inst_out;
  logic [3:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  fetch_count;
  logic        running;

  always #5 clk = ~clk;

  logic [15:0] rom [16];
  assign rom_data = rom[rom_addr];

  fetch_unit #(.ADDR_W(4), .INST_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_count(fetch_count), .running(running)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the program-order stream of PCs decode should accept.
  // Fetch starts at 0 after start, goes sequentially with wrap, and restarts
  // at the target after an honoured redirect. Backpressure and halt never
  // change the stream, only its timing.
  bit          started;
  bit          running_exp;
  int          exp_q[$];
  int          last_push;
  int          xfers;
  bit          hold_prev;
  logic [3:0]  prev_pc;
  logic [15:0] prev_out;
  int          e;

  task automatic model_reset();
    started     = 0;
    running_exp = 0;
    exp_q.delete();
    last_push   = 0;
    xfers       = 0;
  endtask

  // Advance one clock; fold the inputs seen at this edge into the model.
  task automatic tick();
    bit         s_start = start;
    bit         s_halt  = halt;
    bit         s_red   = redirect_valid;
    logic [3:0] s_tgt   = redirect_target;
    @(posedge clk);
    #1;
    if (!started) begin
      if (s_start) begin
        started     = 1;
        running_exp = 1;
        exp_q.delete();
        last_push   = 0;
        exp_q.push_back(0);
      end
    end else begin
      running_exp = !s_halt;
      if (s_red) begin
        exp_q.delete();
        last_push = s_tgt;
        exp_q.push_back(int'(s_tgt));
      end
    end
    if (started)
      while (exp_q.size() < 4) begin
        last_push = (last_push + 1) % 16;
        exp_q.push_back(last_push);
      end
  endtask

  task automatic wait_pc(int p);
    int n = 0;
    while (!(inst_valid && inst_pc == 4'(p)) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) chk($sformatf("timeout_wait_pc_%0d", p), 0, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_inst_out"}, inst_out, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_fetch_count"}, fetch_count, 0);
    chk({tag, "_running"}, running, 0);
  endtask

  // Monitor: inputs are stable at the falling edge, so a transfer seen here
  // is the one the coming rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      chk("fetch_count", fetch_count, (xfers > 255) ? 255 : xfers);
      chk("running", running, running_exp);
      if (hold_prev) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_out", inst_out, prev_out);
      end
      if (inst_valid) chk("inst_out_vs_rom", inst_out, rom[inst_pc]);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc_order", inst_pc, e);
        end
        xfers++;
      end
      hold_prev = inst_valid && !inst_ready && !(started && redirect_valid);
      prev_pc   = inst_pc;
      prev_out  = inst_out;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    rom[0] = 16'hAE01;
    rom[1] = 16'hFE00;
    rst_n = 0; start = 0; halt = 0; redirect_valid = 0;
    redirect_target = 0; inst_ready = 1;
    model_reset();

    // Reset held three cycles, then a start pulse.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    tick();
    start = 1; tick(); start = 0;
    begin
      int n = 0;
      while (xfers < 17 && n < 60) begin tick(); n++; end
      chk("count_after_17", fetch_count, 17);
    end

    // Backpressure at pc 5.
    wait_pc(5);
    inst_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_inst_pc", inst_pc, 5);
      chk("bp_rom_addr", rom_addr, 6);
    end
    inst_ready = 1;

    // Redirect to 12 while pc 3 is accepted.
    wait_pc(3);
    redirect_valid = 1; redirect_target = 12;
    tick();
    redirect_valid = 0;
    chk("redirect_flush_valid", inst_valid, 0);
    wait_pc(12);
    wait_pc(13);

    // Halt at pc 7.
    wait_pc(7);
    halt = 1;
    tick();
    chk("halt_valid", inst_valid, 0);
    chk("halt_running", running, 0);
    tick(); tick();
    chk("halted_valid", inst_valid, 0);
    halt = 0;
    wait_pc(8);

    // start while fetching is ignored (stream must not restart at 0).
    start = 1; tick(); start = 0;
    repeat (3) tick();

    // Asynchronous reset between edges at pc 9.
    wait_pc(9);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1;
    redirect_valid = 1; redirect_target = 9;
    tick();
    redirect_valid = 0;
    chk("idle_redirect_rom_addr", rom_addr, 0);
    chk("idle_valid", inst_valid, 0);
    tick(); tick();
    chk("idle_no_fetch", inst_valid, 0);
    start = 1; tick(); start = 0;
    wait_pc(0);

    // Randomised traffic.
    for (int c = 0; c < 500; c++) begin
      inst_ready      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = 4'($urandom);
      start           = ($urandom_range(0, 29) == 0);
      tick();
    end
    halt = 0; redirect_valid = 0; start = 0; inst_ready = 1;

    // Saturation.
    begin
      int n = 0;
      while (xfers < 300 && n < 1000) begin tick(); n++; end
      chk("saturation_reached", (xfers >= 300) ? 1 : 0, 1);
      chk("fetch_count_sat", fetch_count, 255);
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
